lab3_keypad_scan: RTL and testbench
===================================

Name: lab3_keypad_scan

Overview:
- Scans a 4x4 active-low matrix keypad, debounces one key at a time, and emits a single-cycle `alarm` event plus an 8-bit `keypress` code.
- Feeds the dual-digit seven-segment control stage: `alarm` drives its shift-in strobe and `keypress` its data.
- Guarantees exactly one event per physical press, regardless of contact bounce or hold time.

Parameters:
- SCAN_DIV, 12000, `int_osc` cycles each column is driven before advancing (dwell).
- DEBOUNCE_CYCLES, 240000, consecutive stable cycles required to accept a press or a release.

Ports:
- int_osc  input  1  system clock; all state on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- rows  input  4  raw keypad rows; active-low, pulled up, asynchronous to `int_osc`.
- cols  output  4  column drive; active-low, exactly one bit low at all times.
- alarm  output  1  one-cycle pulse when a press is accepted.
- keypress  output  8  {row_onehot[3:0], col_onehot[3:0]} of the last accepted key, active-high; holds until the next `alarm`.
- key_held  output  1  high from `alarm` until the release is accepted.

Behaviour:
- Reset (async, active-high) sets:
  - `cols` = 4'b1110, `alarm` = 0, `keypress` = 8'h00, `key_held` = 0.
  - State = SCAN; dwell and debounce counters = 0; synchronizer flops = 4'b1111.
- `rows` pass through a 2-flop synchronizer (`rows_s`). All decisions use `rows_s`, which adds 2 cycles of latency.
- States: SCAN, PRESS_DB, HELD, RELEASE_DB.
- SCAN:
  - Dwell counter counts 0..SCAN_DIV-1. `rows_s` is sampled only on the last dwell cycle, so rows settle after a column change.
  - On that cycle, if `rows_s` has exactly one bit low: latch candidate = {~rows_s, ~cols}, go to PRESS_DB, freeze `cols`.
  - Otherwise (no bits low, or two or more low): rotate `cols` left (1110 -> 1101 -> 1011 -> 0111 -> 1110) and clear the dwell counter.
- PRESS_DB:
  - Debounce counter increments each cycle while `~rows_s` equals the candidate row.
  - Any mismatch: clear the counter, return to SCAN at the same column with the dwell counter cleared. No `alarm`.
  - When the counter reaches DEBOUNCE_CYCLES-1 with a match: next cycle `alarm` = 1 for exactly one cycle, `keypress` <= candidate, `key_held` <= 1, go to HELD.
  - Latency: SCAN sample at cycle t gives `alarm` high at cycle t+DEBOUNCE_CYCLES+1.
- HELD:
  - `cols` stay frozen.
  - Additional rows going low are ignored.
  - When the candidate row bit of `rows_s` goes high: go to RELEASE_DB with the counter cleared.
- RELEASE_DB:
  - Counts cycles with the candidate row bit high.
  - If the bit goes low before DEBOUNCE_CYCLES: return to HELD. No new `alarm`; `key_held` stays 1.
  - On expiry: `key_held` <= 0, rotate `cols` to the next column, go to SCAN.
- `alarm` is never asserted in consecutive cycles, and never outside the PRESS_DB->HELD transition.
- A second key pressed while one is held produces no event. It is detected by normal scanning after the first release completes.
- Reset in any state aborts immediately. No `alarm` is generated on reset deassertion.
- Counters are sized $clog2(max(SCAN_DIV, DEBOUNCE_CYCLES)) bits and must not wrap within a phase.

Decomposition:
- Package `lab3_pkg`:
  - `scan_state_t` enum {SCAN, PRESS_DB, HELD, RELEASE_DB}.
  - COL_RESET = 4'b1110, ROWS_IDLE = 4'b1111, KEY_NONE = 8'h00.
- Sub-module `lab3_sync`: parameterised-width 2-flop synchronizer with the same clock/reset, reset value all-ones.
- FSM and counters stay in `lab3_keypad_scan`.

Test Plan (SCAN_DIV=4, DEBOUNCE_CYCLES=8):
- Reset asserted while HELD -> same cycle: `cols`=1110, `key_held`=0, `alarm`=0, `keypress`=00; scan restarts at col0.
- Row1 pulled low while `cols`=1011, held stable -> one `alarm` pulse, `keypress`=8'b0010_0100, `key_held`=1, `cols` frozen at 1011.
- Row0 toggling every 3 cycles for 30 cycles, then stable low -> exactly one `alarm`, `keypress`=8'b0001_0001 (col0 dwell).
- Key held 1000 cycles -> no further `alarm`; release glitch of 5 cycles -> stays HELD; clean release -> `key_held`=0 after 8 cycles, `cols` advances to the next column.
- Rows 1 and 2 low simultaneously in one column -> no `alarm`; `cols` keeps rotating every 4 cycles.
- Key A held, key B (other column) pressed, then A released -> no event for B until A's release completes; then one `alarm` with B's code.

Source files
------------

// File: rtl/lab3_pkg.sv
// Shared types, constants and small helpers for the 4x4 keypad scanner.
package lab3_pkg;

    typedef enum logic [1:0] {
        SCAN       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } scan_state_t;

    localparam logic [3:0] COL_RESET = 4'b1110;
    localparam logic [3:0] ROWS_IDLE = 4'b1111;
    localparam logic [7:0] KEY_NONE  = 8'h00;

    // True when exactly one active-low row is asserted.
    function automatic logic one_low(input logic [3:0] rows);
        logic [3:0] v;
        v = ~rows;
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

    function automatic logic [3:0] rotate_col(input logic [3:0] cols);
        return {cols[2:0], cols[3]};
    endfunction

endpackage

// File: rtl/lab3_sync.sv
// Two-flop synchronizer for asynchronous inputs; resets to all-ones (idle rows).
module lab3_sync #(
    parameter int WIDTH = 4
) (
    input  logic             int_osc,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // NOTE: non-blocking assignments let both flops sample on the same edge; blocking would collapse the chain to one stage.
    always_ff @(posedge int_osc or posedge reset) begin
        if (reset) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/lab3_keypad_scan.sv
// 4x4 active-low keypad scanner: column scan, press/release debounce, one alarm per press.
module lab3_keypad_scan
    import lab3_pkg::*;
#(
    parameter int SCAN_DIV        = 12000,
    parameter int DEBOUNCE_CYCLES = 240000
) (
    input  logic       int_osc,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic       alarm,
    output logic [7:0] keypress,
    output logic       key_held
);

    localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);

    scan_state_t      state;
    scan_state_t      state_next;
    logic [3:0]       rows_s;
    logic [3:0]       cand_row;
    logic [CNT_W-1:0] dwell_cnt;
    logic [CNT_W-1:0] db_cnt;

    logic dwell_inc;
    logic dwell_clr;
    logic db_inc;
    logic db_clr;
    logic latch_cand;
    logic col_rotate;
    logic accept;
    logic release_done;
    logic row_up;

    lab3_sync #(.WIDTH(4)) u_rows_sync (
        .int_osc (int_osc),
        .reset   (reset),
        .d       (rows),
        .q       (rows_s)
    );

    // The candidate row is one-hot, so any high bit in the overlap means that key is up.
    assign row_up = |(rows_s & cand_row);

    always_ff @(posedge int_osc or posedge reset) begin
        if (reset) begin
            state <= SCAN;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first so no path can leave it unassigned and infer a latch.
    always_comb begin
        state_next   = state;
        dwell_inc    = 1'b0;
        dwell_clr    = 1'b0;
        db_inc       = 1'b0;
        db_clr       = 1'b0;
        latch_cand   = 1'b0;
        col_rotate   = 1'b0;
        accept       = 1'b0;
        release_done = 1'b0;

        case (state)
            SCAN: begin
                // Rows are only looked at on the last dwell cycle so they have settled after the column change.
                if (dwell_cnt == DWELL_LAST) begin
                    dwell_clr = 1'b1;
                    if (one_low(rows_s)) begin
                        latch_cand = 1'b1;
                        db_clr     = 1'b1;
                        state_next = PRESS_DB;
                    end else begin
                        col_rotate = 1'b1;
                    end
                end else begin
                    dwell_inc = 1'b1;
                end
            end

            PRESS_DB: begin
                if (~rows_s == cand_row) begin
                    if (db_cnt == DB_LAST) begin
                        accept     = 1'b1;
                        db_clr     = 1'b1;
                        state_next = HELD;
                    end else begin
                        db_inc = 1'b1;
                    end
                end else begin
                    db_clr     = 1'b1;
                    dwell_clr  = 1'b1;
                    state_next = SCAN;
                end
            end

            HELD: begin
                if (row_up) begin
                    db_clr     = 1'b1;
                    state_next = RELEASE_DB;
                end
            end

            RELEASE_DB: begin
                if (row_up) begin
                    if (db_cnt == DB_LAST) begin
                        release_done = 1'b1;
                        col_rotate   = 1'b1;
                        dwell_clr    = 1'b1;
                        db_clr       = 1'b1;
                        state_next   = SCAN;
                    end else begin
                        db_inc = 1'b1;
                    end
                end else begin
                    db_clr     = 1'b1;
                    state_next = HELD;
                end
            end

            default: begin
                state_next = SCAN;
            end
        endcase
    end

    always_ff @(posedge int_osc or posedge reset) begin
        if (reset) begin
            dwell_cnt <= '0;
            db_cnt    <= '0;
            cand_row  <= 4'b0000;
            cols      <= COL_RESET;
            alarm     <= 1'b0;
            keypress  <= KEY_NONE;
            key_held  <= 1'b0;
        end else begin
            if (dwell_clr) begin
                dwell_cnt <= '0;
            end else if (dwell_inc) begin
                dwell_cnt <= dwell_cnt + 1'b1;
            end

            if (db_clr) begin
                db_cnt <= '0;
            end else if (db_inc) begin
                db_cnt <= db_cnt + 1'b1;
            end

            if (latch_cand) begin
                cand_row <= ~rows_s;
            end

            if (col_rotate) begin
                cols <= rotate_col(cols);
            end

            // Columns are frozen from the sample through release, so ~cols still names the pressed column here.
            alarm <= accept;
            if (accept) begin
                keypress <= {cand_row, ~cols};
                key_held <= 1'b1;
            end else if (release_done) begin
                key_held <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lab3_keypad_scan.sv
// Directed bench for lab3_keypad_scan with a small 4x4 matrix model driving rows from cols.
module tb_lab3_keypad_scan;

    logic       int_osc = 1'b0;
    logic       reset   = 1'b1;
    logic [3:0] rows;
    logic [3:0] cols;
    logic       alarm;
    logic [7:0] keypress;
    logic       key_held;

    logic [15:0] keys       = 16'h0000;
    logic        force_en   = 1'b0;
    logic [3:0]  rows_force = 4'b1111;
    logic [3:0]  matrix_rows;

    int tests_run    = 0;
    int tests_failed = 0;
    int alarm_count  = 0;
    int consec_count = 0;
    logic alarm_prev = 1'b0;

    lab3_keypad_scan #(
        .SCAN_DIV        (4),
        .DEBOUNCE_CYCLES (8)
    ) dut (
        .int_osc  (int_osc),
        .reset    (reset),
        .rows     (rows),
        .cols     (cols),
        .alarm    (alarm),
        .keypress (keypress),
        .key_held (key_held)
    );

    always #5 int_osc = ~int_osc;

    // Key (r,c) lives at keys[r*4+c]; it pulls row r low while column c is driven low.
    always_comb begin
        matrix_rows = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !cols[c]) matrix_rows[r] = 1'b0;
            end
        end
    end

    assign rows = force_en ? rows_force : matrix_rows;

    always @(negedge int_osc) begin
        if (alarm === 1'b1) alarm_count++;
        if (alarm === 1'b1 && alarm_prev === 1'b1) consec_count++;
        alarm_prev = alarm;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge int_osc);
            #1;
        end
    endtask

    task automatic wait_alarm(input int max_cycles, output bit found);
        found = 1'b0;
        for (int i = 0; i < max_cycles && !found; i++) begin
            tick(1);
            if (alarm === 1'b1) found = 1'b1;
        end
    endtask

    task automatic wait_release(input int max_cycles, output bit found);
        found = 1'b0;
        for (int i = 0; i < max_cycles && !found; i++) begin
            tick(1);
            if (key_held === 1'b0) found = 1'b1;
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        keys     = 16'h0000;
        force_en = 1'b0;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        tick(1);
        tests_run++;
        if (cols !== 4'b1110) begin
            tests_failed++;
            $display("FAIL reset_cols got %b want 1110", cols);
        end
        tests_run++;
        if (alarm !== 1'b0 || key_held !== 1'b0 || keypress !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_outputs got alarm=%b held=%b key=%h want 0 0 00", alarm, key_held, keypress);
        end
        reset = 1'b0;
    endtask

    task automatic test_latency();
        reset = 1'b1;
        keys  = 16'h0000;
        tick(2);
        keys[0] = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(11);
        tests_run++;
        if (alarm !== 1'b0) begin
            tests_failed++;
            $display("FAIL latency_early got alarm=%b want 0", alarm);
        end
        tick(1);
        tests_run++;
        if (alarm !== 1'b1 || keypress !== 8'h11) begin
            tests_failed++;
            $display("FAIL latency_alarm got alarm=%b key=%h want 1 11", alarm, keypress);
        end
        tick(1);
        tests_run++;
        if (alarm !== 1'b0 || key_held !== 1'b1) begin
            tests_failed++;
            $display("FAIL latency_pulse got alarm=%b held=%b want 0 1", alarm, key_held);
        end
    endtask

    task automatic test_press_col2();
        bit ok;
        int a0;
        do_reset();
        keys[6] = 1'b1;
        wait_alarm(100, ok);
        tests_run++;
        if (!ok || keypress !== 8'b0010_0100) begin
            tests_failed++;
            $display("FAIL press_col2_key got found=%0d key=%b want 1 00100100", ok, keypress);
        end
        tick(1);
        tests_run++;
        if (alarm !== 1'b0 || key_held !== 1'b1 || cols !== 4'b1011) begin
            tests_failed++;
            $display("FAIL press_col2_held got alarm=%b held=%b cols=%b want 0 1 1011", alarm, key_held, cols);
        end
        a0 = alarm_count;
        tick(50);
        tests_run++;
        if (alarm_count != a0 || cols !== 4'b1011) begin
            tests_failed++;
            $display("FAIL press_col2_frozen got alarms=%0d cols=%b want %0d 1011", alarm_count, cols, a0);
        end
    endtask

    task automatic test_reset_in_held();
        #1 reset = 1'b1;
        #1;
        tests_run++;
        if (cols !== 4'b1110 || key_held !== 1'b0 || alarm !== 1'b0 || keypress !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_held got cols=%b held=%b alarm=%b key=%h want 1110 0 0 00",
                     cols, key_held, alarm, keypress);
        end
        keys = 16'h0000;
        tick(2);
        reset = 1'b0;
        tick(3);
        tests_run++;
        if (cols !== 4'b1110) begin
            tests_failed++;
            $display("FAIL reset_restart_col0 got %b want 1110", cols);
        end
        tick(1);
        tests_run++;
        if (cols !== 4'b1101) begin
            tests_failed++;
            $display("FAIL reset_restart_col1 got %b want 1101", cols);
        end
    endtask

    task automatic test_bounce();
        bit ok;
        int a0;
        do_reset();
        a0 = alarm_count;
        for (int i = 0; i < 10; i++) begin
            keys[0] = ~keys[0];
            tick(3);
        end
        keys[0] = 1'b1;
        wait_alarm(100, ok);
        tests_run++;
        if (!ok || keypress !== 8'b0001_0001) begin
            tests_failed++;
            $display("FAIL bounce_key got found=%0d key=%b want 1 00010001", ok, keypress);
        end
        tick(20);
        tests_run++;
        if (alarm_count != a0 + 1) begin
            tests_failed++;
            $display("FAIL bounce_count got %0d want %0d", alarm_count - a0, 1);
        end
    endtask

    task automatic test_hold_release();
        int a0;
        int drops;
        a0 = alarm_count;
        tick(1000);
        tests_run++;
        if (alarm_count != a0 || key_held !== 1'b1) begin
            tests_failed++;
            $display("FAIL long_hold got alarms=%0d held=%b want %0d 1", alarm_count, key_held, a0);
        end
        drops = 0;
        keys[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            if (key_held !== 1'b1) drops++;
        end
        keys[0] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (key_held !== 1'b1) drops++;
        end
        tests_run++;
        if (drops != 0 || alarm_count != a0) begin
            tests_failed++;
            $display("FAIL glitch_release got drops=%0d alarms=%0d want 0 %0d", drops, alarm_count, a0);
        end
        keys[0] = 1'b0;
        tick(10);
        tests_run++;
        if (key_held !== 1'b1) begin
            tests_failed++;
            $display("FAIL release_early got held=%b want 1", key_held);
        end
        tick(1);
        tests_run++;
        if (key_held !== 1'b0 || cols !== 4'b1101 || alarm_count != a0) begin
            tests_failed++;
            $display("FAIL release_done got held=%b cols=%b alarms=%0d want 0 1101 %0d",
                     key_held, cols, alarm_count, a0);
        end
    endtask

    task automatic test_two_rows();
        int a0;
        reset      = 1'b1;
        keys       = 16'h0000;
        force_en   = 1'b1;
        rows_force = 4'b1001;
        tick(2);
        reset = 1'b0;
        a0 = alarm_count;
        tick(3);
        tests_run++;
        if (cols !== 4'b1110) begin
            tests_failed++;
            $display("FAIL two_rows_c0 got %b want 1110", cols);
        end
        tick(1);
        tests_run++;
        if (cols !== 4'b1101) begin
            tests_failed++;
            $display("FAIL two_rows_c1 got %b want 1101", cols);
        end
        tick(4);
        tests_run++;
        if (cols !== 4'b1011) begin
            tests_failed++;
            $display("FAIL two_rows_c2 got %b want 1011", cols);
        end
        tick(4);
        tests_run++;
        if (cols !== 4'b0111) begin
            tests_failed++;
            $display("FAIL two_rows_c3 got %b want 0111", cols);
        end
        tick(4);
        tests_run++;
        if (cols !== 4'b1110 || alarm_count != a0) begin
            tests_failed++;
            $display("FAIL two_rows_wrap got cols=%b alarms=%0d want 1110 %0d", cols, alarm_count, a0);
        end
        force_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        bit ok;
        int a0;
        do_reset();
        keys[9] = 1'b1;
        wait_alarm(100, ok);
        tests_run++;
        if (!ok || keypress !== 8'b0100_0010) begin
            tests_failed++;
            $display("FAIL b2b_key_a got found=%0d key=%b want 1 01000010", ok, keypress);
        end
        a0 = alarm_count;
        keys[15] = 1'b1;
        tick(100);
        tests_run++;
        if (alarm_count != a0 || key_held !== 1'b1 || cols !== 4'b1101) begin
            tests_failed++;
            $display("FAIL b2b_second_ignored got alarms=%0d held=%b cols=%b want %0d 1 1101",
                     alarm_count, key_held, cols, a0);
        end
        keys[9] = 1'b0;
        wait_release(50, ok);
        tests_run++;
        if (!ok || alarm_count != a0) begin
            tests_failed++;
            $display("FAIL b2b_release_a got found=%0d alarms=%0d want 1 %0d", ok, alarm_count, a0);
        end
        wait_alarm(100, ok);
        tests_run++;
        if (!ok || keypress !== 8'b1000_1000 || alarm_count != a0 + 1) begin
            tests_failed++;
            $display("FAIL b2b_key_b got found=%0d key=%b alarms=%0d want 1 10001000 %0d",
                     ok, keypress, alarm_count, a0 + 1);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_press_col2();
        test_reset_in_held();
        test_bounce();
        test_hold_release();
        test_two_rows();
        test_back_to_back();
        tests_run++;
        if (consec_count != 0) begin
            tests_failed++;
            $display("FAIL alarm_consecutive got %0d want 0", consec_count);
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
